// File: rtl/vec_dispatch_pkg.sv
// vec_dispatch_pkg: types and constants shared by the vector dispatch stage.
//   XLEN             scalar datapath width
//   dispatch_state_e dispatch FSM states
//   dispatch_entry_t one queued instruction with its scalar operands
//   CONF_FUNC3       func3 marking vsetvli/vsetivli/vsetvl under V_ARITH
package vec_dispatch_pkg;

  `include "vec_de_csr_defs.svh"

  localparam int XLEN = 32;

  localparam v_func3_e CONF_FUNC3 = OPCFG;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_VL = 1'b1
  } dispatch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
  } dispatch_entry_t;

endpackage

// File: rtl/vec_de_csr_defs.svh
// Shared vector-unit encodings: major opcodes and OP-V func3 field values.
// Included inside a package so the enums land in that package's scope.
`ifndef VEC_DE_CSR_DEFS_SVH
`define VEC_DE_CSR_DEFS_SVH

typedef enum logic [6:0] {
  V_LOAD  = 7'h07,
  V_STORE = 7'h27,
  V_ARITH = 7'h57
} v_opcode_e;

typedef enum logic [2:0] {
  OPIVV = 3'b000,
  OPFVV = 3'b001,
  OPMVV = 3'b010,
  OPIVI = 3'b011,
  OPIVX = 3'b100,
  OPFVF = 3'b101,
  OPMVX = 3'b110,
  OPCFG = 3'b111
} v_func3_e;

`endif

// File: rtl/vec_dispatch_fifo.sv
// vec_dispatch_fifo: DEPTH-entry FIFO of dispatch_entry_t.
//   clk, reset          clock, synchronous active-high reset
//   push, wr_entry      enqueue (ignored when full)
//   pop, rd_entry       dequeue (ignored when empty); rd_entry is the head
//   full, empty, count  occupancy status
module vec_dispatch_fifo
  import vec_dispatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  dispatch_entry_t          wr_entry,
  input  logic                     pop,
  output dispatch_entry_t          rd_entry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  dispatch_entry_t mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_entry = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vec_inst_dispatch.sv
// vec_inst_dispatch: scalar-side issue stage for the vector unit.
// Buffers vector instructions plus rs1/rs2 values and hands them to vec_decode
// over valid/ready. Config instructions block further issue until the new vl
// returned by the CSR block has been written back to scalar rd.
//   s_valid/s_ready/s_inst/s_rs1_data/s_rs2_data  scalar-side request
//   v_valid/v_ready/v_inst/v_rs1_data/v_rs2_data  vector-decode side
//   cfg_vl_valid/cfg_vl                           vl return from CSR block
//   rd_wr_en/rd_addr/rd_data                      scalar regfile write-back
//   cfg_busy, illegal, count                      status
// Optional feature: define VEC_DISPATCH_BYPASS_EN to let an instruction pass
// straight from s_* to v_* when the FIFO is empty.
module vec_inst_dispatch
  import vec_dispatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [XLEN-1:0]        s_inst,
  input  logic [XLEN-1:0]        s_rs1_data,
  input  logic [XLEN-1:0]        s_rs2_data,
  output logic                   v_valid,
  input  logic                   v_ready,
  output logic [XLEN-1:0]        v_inst,
  output logic [XLEN-1:0]        v_rs1_data,
  output logic [XLEN-1:0]        v_rs2_data,
  input  logic                   cfg_vl_valid,
  input  logic [XLEN-1:0]        cfg_vl,
  output logic                   rd_wr_en,
  output logic [4:0]             rd_addr,
  output logic [XLEN-1:0]        rd_data,
  output logic                   cfg_busy,
  output logic                   illegal,
  output logic [$clog2(DEPTH):0] count
);

  dispatch_state_e state;
  dispatch_entry_t s_entry;
  dispatch_entry_t head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            is_vec;
  logic            is_cfg;
  logic            s_fire;
  logic            push;
  logic            pop;
  logic [4:0]      rd_latched;

  assign is_vec = (s_inst[6:0] == V_ARITH) || (s_inst[6:0] == V_LOAD) ||
                  (s_inst[6:0] == V_STORE);
  assign is_cfg = (s_inst[6:0] == V_ARITH) && (s_inst[14:12] == CONF_FUNC3);

  assign s_ready = !reset && !fifo_full && (state == IDLE);
  assign s_fire  = s_valid && s_ready;
  assign s_entry = '{inst: s_inst, rs1_data: s_rs1_data, rs2_data: s_rs2_data};

`ifdef VEC_DISPATCH_BYPASS_EN
  logic byp;
  // Gated by s_ready so nothing is offered downstream that the scalar side
  // could not actually hand over this cycle.
  assign byp        = fifo_empty && s_valid && is_vec && s_ready;
  assign push       = s_fire && is_vec && !(byp && v_ready);
  assign pop        = !fifo_empty && v_ready;
  assign v_valid    = !fifo_empty || byp;
  assign v_inst     = fifo_empty ? s_inst     : head.inst;
  assign v_rs1_data = fifo_empty ? s_rs1_data : head.rs1_data;
  assign v_rs2_data = fifo_empty ? s_rs2_data : head.rs2_data;
`else
  assign push       = s_fire && is_vec;
  assign pop        = !fifo_empty && v_ready;
  assign v_valid    = !fifo_empty;
  assign v_inst     = head.inst;
  assign v_rs1_data = head.rs1_data;
  assign v_rs2_data = head.rs2_data;
`endif

  vec_dispatch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .wr_entry (s_entry),
    .pop      (pop),
    .rd_entry (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_latched <= '0;
      rd_wr_en   <= 1'b0;
      rd_addr    <= '0;
      rd_data    <= '0;
      cfg_busy   <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      rd_wr_en <= 1'b0;
      illegal  <= s_fire && !is_vec;
      case (state)
        IDLE: begin
          if (s_fire && is_cfg) begin
            state      <= WAIT_VL;
            rd_latched <= s_inst[11:7];
            cfg_busy   <= 1'b1;
          end
        end
        WAIT_VL: begin
          if (cfg_vl_valid) begin
            state    <= IDLE;
            cfg_busy <= 1'b0;
            // x0 is hardwired zero: complete the round-trip without a write.
            rd_wr_en <= (rd_latched != 5'd0);
            rd_addr  <= rd_latched;
            rd_data  <= cfg_vl;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_inst_dispatch.sv
module tb_vec_inst_dispatch;
  import vec_dispatch_pkg::*;

  localparam logic [31:0] VADD        = 32'h0221_80D7;
  localparam logic [31:0] VSETVLI     = 32'h0105_F557;
  localparam logic [31:0] VSETVLI_X0  = 32'h0105_F057;
  localparam logic [31:0] ADD_SCALAR  = 32'h0020_8033;

  logic              clk = 1'b0;
  logic              reset;
  logic              s_valid;
  logic              s_ready;
  logic [XLEN-1:0]   s_inst;
  logic [XLEN-1:0]   s_rs1_data;
  logic [XLEN-1:0]   s_rs2_data;
  logic              v_valid;
  logic              v_ready;
  logic [XLEN-1:0]   v_inst;
  logic [XLEN-1:0]   v_rs1_data;
  logic [XLEN-1:0]   v_rs2_data;
  logic              cfg_vl_valid;
  logic [XLEN-1:0]   cfg_vl;
  logic              rd_wr_en;
  logic [4:0]        rd_addr;
  logic [XLEN-1:0]   rd_data;
  logic              cfg_busy;
  logic              illegal;
  logic [2:0]        count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vec_inst_dispatch #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_inst       (s_inst),
    .s_rs1_data   (s_rs1_data),
    .s_rs2_data   (s_rs2_data),
    .v_valid      (v_valid),
    .v_ready      (v_ready),
    .v_inst       (v_inst),
    .v_rs1_data   (v_rs1_data),
    .v_rs2_data   (v_rs2_data),
    .cfg_vl_valid (cfg_vl_valid),
    .cfg_vl       (cfg_vl),
    .rd_wr_en     (rd_wr_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .cfg_busy     (cfg_busy),
    .illegal      (illegal),
    .count        (count)
  );

  task automatic check_vec(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] burst_inst(input int i);
    return VADD ^ (32'(i) << 15);
  endfunction

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_inst = '0; s_rs1_data = '0; s_rs2_data = '0;
    v_ready = 1'b0; cfg_vl_valid = 1'b0; cfg_vl = '0;
    step(); step();
    #1;
    check_vec("rst_s_ready",  s_ready,  0);
    check_vec("rst_v_valid",  v_valid,  0);
    check_vec("rst_count",    count,    0);
    check_vec("rst_cfg_busy", cfg_busy, 0);
    check_vec("rst_rd_wr_en", rd_wr_en, 0);
    check_vec("rst_illegal",  illegal,  0);
    check_vec("rst_rd_addr",  rd_addr,  0);
    check_vec("rst_rd_data",  rd_data,  0);
    reset = 1'b0;
    #1;
    check_vec("post_rst_s_ready", s_ready, 1);

    // single vadd.vv with consumer ready
    s_valid = 1'b1; s_inst = VADD; s_rs1_data = 32'h11; s_rs2_data = 32'h22;
    v_ready = 1'b1;
    #1;
`ifdef VEC_DISPATCH_BYPASS_EN
    check_vec("byp_v_valid", v_valid, 1);
    check_vec("byp_v_inst",  v_inst,  VADD);
    check_vec("byp_v_rs1",   v_rs1_data, 32'h11);
    step();
    s_valid = 1'b0;
    #1;
    check_vec("byp_count", count, 0);
    check_vec("byp_v_valid_after", v_valid, 0);
`else
    check_vec("t1_v_valid_same_cycle", v_valid, 0);
    step();
    s_valid = 1'b0;
    #1;
    check_vec("t1_v_valid", v_valid, 1);
    check_vec("t1_v_inst",  v_inst,  VADD);
    check_vec("t1_v_rs1",   v_rs1_data, 32'h11);
    check_vec("t1_v_rs2",   v_rs2_data, 32'h22);
    check_vec("t1_count",   count, 1);
    step();
    #1;
    check_vec("t1_count_drained", count, 0);
    check_vec("t1_v_valid_drained", v_valid, 0);
`endif
    check_vec("t1_rd_wr_en", rd_wr_en, 0);

    // five back-to-back vadds against a stalled consumer
    v_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_inst = burst_inst(i); s_rs1_data = 32'(i); s_rs2_data = 32'h100 + 32'(i);
      #1;
      check_vec("t2_s_ready_fill", s_ready, 1);
      step();
    end
    s_inst = burst_inst(4); s_rs1_data = 32'd4; s_rs2_data = 32'h104;
    #1;
    check_vec("t2_s_ready_full", s_ready, 0);
    check_vec("t2_count_full",   count, 4);
    check_vec("t2_head0",        v_inst, burst_inst(0));
    step();
    #1;
    check_vec("t2_count_held", count, 4);
    v_ready = 1'b1;
    #1;
    check_vec("t2_s_ready_full_pop", s_ready, 0);
    step();
    #1;
    check_vec("t2_count_after_pop", count, 3);
    check_vec("t2_head1", v_inst, burst_inst(1));
    check_vec("t2_s_ready_reopen", s_ready, 1);
    step();
    s_valid = 1'b0;
    #1;
    check_vec("t2_count_push_pop", count, 3);
    check_vec("t2_head2", v_inst, burst_inst(2));
    step();
    #1;
    check_vec("t2_head3", v_inst, burst_inst(3));
    check_vec("t2_count_2", count, 2);
    step();
    #1;
    check_vec("t2_head4", v_inst, burst_inst(4));
    check_vec("t2_head4_rs1", v_rs1_data, 32'd4);
    check_vec("t2_count_1", count, 1);
    step();
    #1;
    check_vec("t2_count_empty", count, 0);
    check_vec("t2_v_valid_empty", v_valid, 0);

    // vsetvli x10 round-trip
    v_ready = 1'b0;
    s_valid = 1'b1; s_inst = VSETVLI; s_rs1_data = 32'd5; s_rs2_data = 32'd0;
    #1;
    check_vec("t3_s_ready_idle", s_ready, 1);
    step();
    s_inst = VADD; s_rs1_data = 32'h33; s_rs2_data = 32'h44;
    v_ready = 1'b1;
    #1;
    check_vec("t3_cfg_busy",  cfg_busy, 1);
    check_vec("t3_s_ready_wait", s_ready, 0);
    check_vec("t3_v_valid",   v_valid, 1);
    check_vec("t3_v_inst",    v_inst, VSETVLI);
    check_vec("t3_count",     count, 1);
    step();
    #1;
    check_vec("t3_count_drained", count, 0);
    check_vec("t3_cfg_busy_1", cfg_busy, 1);
    check_vec("t3_s_ready_1",  s_ready, 0);
    step();
    #1;
    check_vec("t3_rd_wr_en_wait", rd_wr_en, 0);
    check_vec("t3_cfg_busy_2", cfg_busy, 1);
    step();
    cfg_vl_valid = 1'b1; cfg_vl = 32'd8; v_ready = 1'b0;
    #1;
    check_vec("t3_cfg_busy_3", cfg_busy, 1);
    step();
    cfg_vl_valid = 1'b0;
    #1;
    check_vec("t3_rd_wr_en",  rd_wr_en, 1);
    check_vec("t3_rd_addr",   rd_addr, 10);
    check_vec("t3_rd_data",   rd_data, 8);
    check_vec("t3_cfg_busy_done", cfg_busy, 0);
    check_vec("t3_s_ready_back", s_ready, 1);
    step();
    s_valid = 1'b0;
    #1;
    check_vec("t3_rd_wr_en_pulse", rd_wr_en, 0);
    check_vec("t3_count_next", count, 1);
    check_vec("t3_next_inst", v_inst, VADD);
    v_ready = 1'b1;
    step();
    #1;
    check_vec("t3_count_final", count, 0);

    // vsetvli with rd = x0, plus cfg_vl_valid while idle
    v_ready = 1'b0;
    s_valid = 1'b1; s_inst = VSETVLI_X0;
    step();
    s_valid = 1'b0; cfg_vl_valid = 1'b1; cfg_vl = 32'd16;
    #1;
    check_vec("t4_cfg_busy", cfg_busy, 1);
    step();
    #1;
    check_vec("t4_rd_wr_en_x0", rd_wr_en, 0);
    check_vec("t4_cfg_busy_done", cfg_busy, 0);
    check_vec("t4_s_ready", s_ready, 1);
    step();
    cfg_vl_valid = 1'b0;
    #1;
    check_vec("t4_idle_vl_ignored", rd_wr_en, 0);
    check_vec("t4_idle_busy", cfg_busy, 0);
    v_ready = 1'b1;
    step();
    #1;
    check_vec("t4_count_drained", count, 0);

    // scalar add is accepted and dropped
    v_ready = 1'b0;
    s_valid = 1'b1; s_inst = ADD_SCALAR;
    #1;
    check_vec("t5_s_ready", s_ready, 1);
    check_vec("t5_v_valid_same", v_valid, 0);
    step();
    s_valid = 1'b0;
    #1;
    check_vec("t5_illegal", illegal, 1);
    check_vec("t5_count",   count, 0);
    check_vec("t5_v_valid", v_valid, 0);
    step();
    #1;
    check_vec("t5_illegal_pulse", illegal, 0);

    // reset while waiting for vl with two entries queued
    s_valid = 1'b1; s_inst = VADD;
    step();
    s_inst = VSETVLI;
    step();
    s_valid = 1'b0;
    #1;
    check_vec("t6_count_2", count, 2);
    check_vec("t6_cfg_busy", cfg_busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_vec("t6_count_rst",    count, 0);
    check_vec("t6_v_valid_rst",  v_valid, 0);
    check_vec("t6_cfg_busy_rst", cfg_busy, 0);
    cfg_vl_valid = 1'b1; cfg_vl = 32'd8;
    step();
    cfg_vl_valid = 1'b0;
    #1;
    check_vec("t6_no_writeback", rd_wr_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
